// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter and its picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int NUM_CORES_DEF = 4;
  localparam int MAX_HOLD_DEF  = 16;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] sel,
  output logic           valid
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      // ptr < N, so one conditional subtract performs the modulo
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!valid && req[idx]) begin
        valid = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with registered one-hot grant and one dead cycle per release.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ID_W      = id_width(NUM_CORES),
  parameter int MAX_HOLD  = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] req,
  input  logic [NUM_CORES-1:0] done,
  output logic [NUM_CORES-1:0] gnt,
  output logic [ID_W-1:0]      gnt_id,
  output logic                 bus_busy,
  output logic                 timeout
);

  arb_state_e           state_q, state_d;
  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 timeout_q, timeout_d;
  logic [ID_W-1:0]      pick_sel;
  logic                 pick_vld;
  logic                 release_w;
  logic                 expire_w;

  rr_pick #(
    .N   (NUM_CORES),
    .IDW (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .sel   (pick_sel),
    .valid (pick_vld)
  );

  // Completion and abandonment of the owner collapse into one release.
  assign release_w = done[gnt_id_q] | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q;

  // Held at zero outside GRANT so each new grant starts counting from zero.
  always_ff @(posedge clk) begin
    if (!rst_n)                hold_q <= '0;
    else if (state_q == GRANT) hold_q <= hold_q + 1'b1;
    else                       hold_q <= '0;
  end

  assign expire_w = (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
  logic unused_hold;
  assign unused_hold = (MAX_HOLD == 0);
  assign expire_w    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[pick_sel] = 1'b1;
          gnt_id_d        = pick_sel;
          ptr_d           = (pick_sel == ID_W'(NUM_CORES - 1)) ? '0 : pick_sel + 1'b1;
        end
      end
      GRANT: begin
        if (release_w || expire_w) begin
          state_d   = GAP;
          gnt_d     = '0;
          gnt_id_d  = '0;
          timeout_d = ~release_w;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign bus_busy = (state_q != IDLE);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized and directed bench for bus_arbiter_rr against a cycle-level reference model.
module tb_bus_arbiter_rr;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int MAXH = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           bus_busy;
  logic           timeout;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: owner index (-1 = bus free), dead-cycle flag, rotation pointer.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_gap   = 1'b0;
  bit m_to    = 1'b0;

  bus_arbiter_rr #(
    .NUM_CORES (N),
    .ID_W      (IDW),
    .MAX_HOLD  (MAXH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit bitat(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  task automatic model_edge();
    bit rel;
    bit expired;
    int cand;
    m_to = 1'b0;
    if (!rst_n) begin
      m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_hold = 0;
    end else if (m_owner >= 0) begin
      rel = bitat(done, m_owner) || !bitat(req, m_owner);
`ifdef ARB_TIMEOUT_EN
      expired = (m_hold + 1 >= MAXH);
`else
      expired = 1'b0;
`endif
      if (rel || expired) begin
        m_to = !rel; m_owner = -1; m_gap = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (m_owner < 0 && bitat(req, cand)) m_owner = cand;
      end
      if (m_owner >= 0) begin
        m_ptr  = (m_owner + 1) % N;
        m_hold = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("gnt", 32'(gnt), eg);
    chk("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("bus_busy", 32'(bus_busy), 32'((m_owner >= 0) || m_gap));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
    rst_n = r; req = rq; done = dn;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int since, zeros, ng, run, to_cnt;
    bit in_run;
    logic [N-1:0] prev, dn, rq;

    rst_n = 1'b0; req = '0; done = '0;
    // Reset, single request, release through the dead cycle.
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    step(1, 4'b0001, 4'b0000);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_id", 32'(gnt_id), 32'd0);
    step(1, 4'b0001, 4'b0001);
    chk("t1_gap_gnt", 32'(gnt), 32'd0);
    chk("t1_gap_busy", 32'(bus_busy), 32'd1);
    step(1, 4'b0000, 4'b0000);
    chk("t1_idle_busy", 32'(bus_busy), 32'd0);

    // All cores requesting, each owner finishes a few cycles after its grant.
    step(0, 4'b0000, 4'b0000);
    since = 0; zeros = 0; ng = 0; prev = '0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      dn = (gnt != '0 && since == 2) ? gnt : '0;
      step(1, 4'b1111, dn);
      if (gnt != '0 && prev == '0) begin
        chk($sformatf("order%0d", ng), 32'(gnt_id), 32'(ng % N));
        if (ng > 0) chk("gap_min", 32'(zeros >= 2), 32'd1);
        ng++; since = 0; zeros = 0;
      end else if (gnt != '0) begin
        since++;
      end else begin
        zeros++;
      end
      prev = gnt;
    end
    chk("order_cnt", 32'(ng), 32'd5);
    for (int c = 0; c < 3; c++) step(1, 4'b0000, 4'b0000);

    // Foreign done ignored; owner abandons by dropping its request.
    step(1, 4'b0100, 4'b0000);
    chk("t3_gnt", 32'(gnt), 32'h4);
    step(1, 4'b0100, 4'b0010);
    chk("t3_ignore", 32'(gnt), 32'h4);
    step(1, 4'b0000, 4'b0000);
    chk("t3_drop_gnt", 32'(gnt), 32'd0);
    chk("t3_drop_busy", 32'(bus_busy), 32'd1);
    step(1, 4'b0000, 4'b0000);

    // Move pointer to 2, then 1010 must grant core 3 before core 1.
    step(1, 4'b0010, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    step(1, 4'b1010, 4'b0000);
    chk("t4_first", 32'(gnt), 32'h8);
    step(1, 4'b1010, 4'b1000);
    step(1, 4'b0010, 4'b0000);
    step(1, 4'b0010, 4'b0000);
    chk("t4_second", 32'(gnt), 32'h2);
    for (int c = 0; c < 3; c++) step(1, 4'b0000, 4'b0000);

    // Owner never finishes.
    step(1, 4'b0011, 4'b0000);
    chk("t5_gnt", 32'(gnt), 32'h1);
    run = 1; in_run = 1'b1; to_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      step(1, 4'b0011, 4'b0000);
      if (timeout) to_cnt++;
      if (in_run && gnt == 4'b0001) run++;
      else in_run = 1'b0;
    end
`ifdef ARB_TIMEOUT_EN
    chk("t5_run", 32'(run), 32'(MAXH));
    chk("t5_timeout_seen", 32'(to_cnt > 0), 32'd1);
`else
    chk("t5_run", 32'(run), 32'd101);
    chk("t5_timeout_cnt", 32'(to_cnt), 32'd0);
`endif
    for (int c = 0; c < 3; c++) step(1, 4'b0000, 4'b0000);

    // Reset while core 3 owns the bus.
    step(1, 4'b1000, 4'b0000);
    chk("t6_gnt", 32'(gnt), 32'h8);
    step(1, 4'b1000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_id", 32'(gnt_id), 32'd0);
    chk("t6_rst_busy", 32'(bus_busy), 32'd0);
    step(1, 4'b1111, 4'b0000);
    chk("t6_after", 32'(gnt), 32'h1);
    for (int c = 0; c < 3; c++) step(1, 4'b0000, 4'b0000);

    // Random traffic: sticky requests, random done, rare resets.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      dn = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) dn[b] = 1'b1;
      step(($urandom_range(0, 299) != 0), rq, dn);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
